op_issuer: RTL and testbench

//   Initiator side of the core operation handshake (start_op/op_sel/A/B/address_in/data_in -> end_op/result).

---
 rtl/op_issuer.sv | 168 ++++++++++++++++
 tb/tb_op_issuer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/op_issuer.sv
// Initiator side of the core operation handshake: queues host commands in a FIFO,
// issues them one at a time to the core and returns each result (or a timeout) on a response port.
module op_issuer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned OP_W    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [OP_W-1:0] cmd_op,
  input  logic [7:0]      cmd_a,
  input  logic [7:0]      cmd_b,
  input  logic [11:0]     cmd_addr,
  input  logic [7:0]      cmd_data,
  output logic            start_op,
  output logic [OP_W-1:0] op_sel,
  output logic [7:0]      A,
  output logic [7:0]      B,
  output logic [11:0]     address_in,
  output logic [7:0]      data_in,
  input  logic            end_op,
  input  logic [15:0]     result,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [15:0]     rsp_result,
  output logic            rsp_timeout,
  output logic            busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam int unsigned EW = OP_W + 8 + 8 + 12 + 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [EW-1:0]   mem [DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
  logic            empty, full, full_d, push, pop;
  logic [EW-1:0]   head;
  logic [OP_W-1:0] h_op;
  logic [7:0]      h_a, h_b, h_data;
  logic [11:0]     h_addr;

  logic [1:0]      state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            start_op_d, rsp_valid_d, rsp_timeout_d, busy_d;
  logic [OP_W-1:0] op_sel_d;
  logic [7:0]      a_d, b_d, data_in_d;
  logic [11:0]     address_in_d;
  logic [15:0]     rsp_result_d;

  // FIFO status: pointers carry an extra wrap bit to tell full from empty
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = cmd_valid && cmd_ready && !full;
  assign head  = mem[rd_ptr[AW-1:0]];
  assign {h_op, h_a, h_b, h_addr, h_data} = head;

  assign wr_ptr_d = wr_ptr + (AW+1)'(push);
  assign rd_ptr_d = rd_ptr + (AW+1)'(pop);
  assign full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {cmd_op, cmd_a, cmd_b, cmd_addr, cmd_data};
  end

  // Next-state and next-output logic for the issue FSM
  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    pop           = 1'b0;
    start_op_d    = start_op;
    op_sel_d      = op_sel;
    a_d           = A;
    b_d           = B;
    address_in_d  = address_in;
    data_in_d     = data_in;
    rsp_valid_d   = rsp_valid;
    rsp_result_d  = rsp_result;
    rsp_timeout_d = rsp_timeout;
    case (state)
      S_IDLE: begin
        // a core still asserting end_op has not released the previous op yet
        if (!empty && !end_op) begin
          pop          = 1'b1;
          op_sel_d     = h_op;
          a_d          = h_a;
          b_d          = h_b;
          address_in_d = h_addr;
          data_in_d    = h_data;
          start_op_d   = 1'b1;
          cnt_d        = '0;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (end_op) begin
          rsp_result_d  = result;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          start_op_d    = 1'b0;
          state_d       = S_RESP;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          rsp_result_d  = '0;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          start_op_d    = 1'b0;
          state_d       = S_RESP;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        start_op_d  = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE) || (wr_ptr_d != rd_ptr_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cmd_ready   <= 1'b0;
      start_op    <= 1'b0;
      op_sel      <= '0;
      A           <= '0;
      B           <= '0;
      address_in  <= '0;
      data_in     <= '0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      wr_ptr      <= wr_ptr_d;
      rd_ptr      <= rd_ptr_d;
      cmd_ready   <= !full_d;
      start_op    <= start_op_d;
      op_sel      <= op_sel_d;
      A           <= a_d;
      B           <= b_d;
      address_in  <= address_in_d;
      data_in     <= data_in_d;
      rsp_valid   <= rsp_valid_d;
      rsp_result  <= rsp_result_d;
      rsp_timeout <= rsp_timeout_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_op_issuer.sv
// Directed bench for op_issuer: bench-driven core responses, hand-computed expected values.
module tb_op_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_op;
  logic [7:0]  cmd_a, cmd_b, cmd_data;
  logic [11:0] cmd_addr;
  logic        start_op;
  logic [3:0]  op_sel;
  logic [7:0]  A, B, data_in;
  logic [11:0] address_in;
  logic        end_op;
  logic [15:0] result;
  logic        rsp_valid, rsp_ready, rsp_timeout, busy;
  logic [15:0] rsp_result;

  int   n_vec = 0;
  int   n_err = 0;
  logic auto_core = 1'b0;

  always #5 clk = ~clk;

  op_issuer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .start_op(start_op), .op_sel(op_sel), .A(A), .B(B),
    .address_in(address_in), .data_in(data_in),
    .end_op(end_op), .result(result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  // Advance one cycle; the optional core model answers one cycle after start_op with {A,B}
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_core) begin
      end_op = start_op;
      result = {A, B};
    end
  endtask

  task automatic push_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [11:0] addr, input logic [7:0] data);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_addr = addr; cmd_data = data;
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL push_ready: cmd_ready=%b required 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int k = 0;
    while (start_op !== 1'b1 && k < 50) begin tick(); k++; end
    n_vec++;
    if (start_op !== 1'b1) begin
      n_err++; $display("FAIL %s_start: start_op=%b required 1 within 50 cycles", tag, start_op);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; cmd_valid = 1'b0; end_op = 1'b0; result = '0; rsp_ready = 1'b0;
    cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_addr = '0; cmd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({cmd_ready, start_op, rsp_valid, rsp_timeout, busy} !== 5'b0 || rsp_result !== 16'h0 ||
        op_sel !== 4'h0 || address_in !== 12'h0) begin
      n_err++;
      $display("FAIL reset_outputs: rdy=%b start=%b rv=%b to=%b busy=%b res=%h required all 0",
               cmd_ready, start_op, rsp_valid, rsp_timeout, busy, rsp_result);
    end
    rst = 1'b1;
    tick();
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_release_ready: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_store();
    int hi = 0;
    int k = 0;
    logic stable = 1'b1;
    push_cmd(4'h3, 8'h00, 8'h00, 12'h011, 8'hFE);
    n_vec++;
    if (start_op !== 1'b0 || busy !== 1'b1) begin
      n_err++; $display("FAIL store_latency: start_op=%b busy=%b required 0/1 after push edge", start_op, busy);
    end
    wait_start("store");
    n_vec++;
    if (op_sel !== 4'h3) begin
      n_err++; $display("FAIL store_op_sel: op_sel=%h required 3", op_sel);
    end
    while (start_op === 1'b1 && k < 100) begin
      hi++;
      if (address_in !== 12'h011 || data_in !== 8'hFE) stable = 1'b0;
      if (k == 3) begin end_op = 1'b1; result = 16'h0000; end
      tick();
      k++;
    end
    end_op = 1'b0;
    n_vec++;
    if (hi != 4) begin
      n_err++; $display("FAIL store_start_width: start_op high %0d cycles required 4", hi);
    end
    n_vec++;
    if (stable !== 1'b1) begin
      n_err++; $display("FAIL store_operands_stable: address_in/data_in changed, required 011/FE");
    end
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_result !== 16'h0 || rsp_timeout !== 1'b0) begin
      n_err++;
      $display("FAIL store_rsp: rv=%b res=%h to=%b required 1/0000/0", rsp_valid, rsp_result, rsp_timeout);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_vec++;
    if (rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL store_rsp_consume: rsp_valid=%b required 0", rsp_valid);
    end
  endtask

  task automatic test_add();
    push_cmd(4'h1, 8'hFF, 8'hFE, 12'h000, 8'h00);
    wait_start("add");
    n_vec++;
    if (A !== 8'hFF || B !== 8'hFE || op_sel !== 4'h1) begin
      n_err++; $display("FAIL add_operands: A=%h B=%h op=%h required FF/FE/1", A, B, op_sel);
    end
    end_op = 1'b1; result = 16'h01FD;
    tick();
    n_vec++;
    if (start_op !== 1'b0 || rsp_valid !== 1'b1 || rsp_result !== 16'h01FD) begin
      n_err++;
      $display("FAIL add_rsp: start=%b rv=%b res=%h required 0/1/01FD", start_op, rsp_valid, rsp_result);
    end
    end_op = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] va [6];
    logic [7:0] vb [6];
    for (int i = 0; i < 6; i++) begin
      va[i] = 8'(8'h10 + 8'(i));
      vb[i] = 8'(8'hA0 + 8'(3 * i));
    end
    end_op = 1'b0;
    rsp_ready = 1'b0;
    auto_core = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1; cmd_op = 4'h2; cmd_a = va[i]; cmd_b = vb[i];
      cmd_addr = 12'(i); cmd_data = 8'(i);
      n_vec++;
      if (cmd_ready !== (i < 5)) begin
        n_err++; $display("FAIL b2b_ready_%0d: cmd_ready=%b required %b", i, cmd_ready, (i < 5));
      end
      tick();
    end
    cmd_valid = 1'b0;
    n_vec++;
    if (rsp_valid !== 1'b1 || busy !== 1'b1 || start_op !== 1'b0) begin
      n_err++; $display("FAIL b2b_parked: rv=%b busy=%b start=%b required 1/1/0", rsp_valid, busy, start_op);
    end
    rsp_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      int k = 0;
      while (rsp_valid !== 1'b1 && k < 50) begin tick(); k++; end
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_result !== {va[j], vb[j]}) begin
        n_err++;
        $display("FAIL b2b_order_%0d: rv=%b res=%h required 1/%h", j, rsp_valid, rsp_result, {va[j], vb[j]});
      end
      tick();
    end
    tick(); tick();
    n_vec++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_drained: busy=%b rv=%b required 0/0", busy, rsp_valid);
    end
    auto_core = 1'b0;
    end_op = 1'b0;
    rsp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int hi = 0;
    end_op = 1'b0;
    push_cmd(4'h5, 8'h12, 8'h34, 12'h0AB, 8'h56);
    wait_start("timeout");
    while (start_op === 1'b1 && hi < 200) begin hi++; tick(); end
    n_vec++;
    if (hi != 64) begin
      n_err++; $display("FAIL timeout_width: start_op high %0d cycles required 64", hi);
    end
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_timeout !== 1'b1 || rsp_result !== 16'h0) begin
      n_err++;
      $display("FAIL timeout_rsp: rv=%b to=%b res=%h required 1/1/0000", rsp_valid, rsp_timeout, rsp_result);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_end_op_held();
    logic low_ok = 1'b1;
    cmd_valid = 1'b1; cmd_op = 4'h1; cmd_a = 8'h21; cmd_b = 8'h43; cmd_addr = 12'h0; cmd_data = 8'h0;
    tick();
    cmd_a = 8'h65; cmd_b = 8'h87;
    tick();
    cmd_valid = 1'b0;
    wait_start("held_first");
    end_op = 1'b1; result = 16'h1234;
    tick();
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (start_op !== 1'b0) low_ok = 1'b0;
    end
    n_vec++;
    if (low_ok !== 1'b1) begin
      n_err++; $display("FAIL held_no_issue: start_op rose while end_op held high, required 0");
    end
    end_op = 1'b0;
    tick();
    n_vec++;
    if (start_op !== 1'b1 || A !== 8'h65 || B !== 8'h87) begin
      n_err++; $display("FAIL held_release: start=%b A=%h B=%h required 1/65/87", start_op, A, B);
    end
    end_op = 1'b1; result = 16'h6587;
    tick();
    end_op = 1'b0;
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_result !== 16'h6587) begin
      n_err++; $display("FAIL held_second_rsp: rv=%b res=%h required 1/6587", rsp_valid, rsp_result);
    end
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    logic quiet = 1'b1;
    end_op = 1'b0;
    cmd_valid = 1'b1; cmd_op = 4'h7; cmd_a = 8'h01; cmd_b = 8'h02; cmd_addr = 12'h3; cmd_data = 8'h4;
    tick(); tick();
    cmd_valid = 1'b0;
    wait_start("mid_reset");
    tick();
    #3;
    rst = 1'b0;
    #1;
    n_vec++;
    if (start_op !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL async_reset: start=%b rv=%b busy=%b required 0/0/0 without edge",
                        start_op, rsp_valid, busy);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    n_vec++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL post_reset: rdy=%b busy=%b rv=%b required 1/0/0", cmd_ready, busy, rsp_valid);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      if (start_op !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    n_vec++;
    if (quiet !== 1'b1) begin
      n_err++; $display("FAIL post_reset_fifo_empty: queued command issued after reset, required none");
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_add();
    test_back_to_back();
    test_timeout();
    test_end_op_held();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
